pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, optional skid buffer, and synchronous flush. It is the generic successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage RISC-V pipeline. It carries a data field and a control field separately; the control field reads zero whenever the stage holds a bubble, so side-effecting controls (memory write enable, register write-back) can never fire on an invalid slot. Stalls propagate by backpressure instead of a global enable.

## Interface
- DATA_W, 96: width of the non-side-effecting payload (operands, immediate, Rd).
- CTRL_W, 8: width of the control payload (ALU ctrl, ALU src, MEM wen, WB sel); zeroed on bubbles.
- SKID, 1: 1 selects a 2-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of all held entries (branch mispredict / trap).
- in_valid  in  1  upstream slot valid.
- in_ready  out  1  stage accepts the input this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  downstream slot valid.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  held data payload.
- out_ctrl  out  CTRL_W  held control payload; 0 when out_valid=0.
- occupancy  out  2  number of held entries (0..2; never exceeds 1 when SKID=0).

## Operation
- Transfer in: in_valid & in_ready at the edge. Transfer out: out_valid & out_ready at the edge.
- State (SKID=1): EMPTY, BUSY (main entry only), FULL (main + skid entry).
  - EMPTY: in_valid -> BUSY, main <= input.
  - BUSY: in_valid & out_ready -> BUSY, main <= input; in_valid & !out_ready -> FULL, skid <= input; !in_valid & out_ready -> EMPTY; otherwise hold.
  - FULL: out_ready -> BUSY, main <= skid; otherwise hold. No input is accepted in FULL.
- in_ready (SKID=1) = (state != FULL). It is registered and does not depend on out_ready.
- SKID=0: states EMPTY and BUSY only. in_ready = out_ready | !out_valid (combinational). An input accepted with out_ready=1 replaces main in the same edge.
- flush: takes priority over every transfer. Next state is EMPTY and any input offered that cycle is dropped. in_ready is not forced low during flush; an upstream transfer in that cycle is completed and discarded.
- reset: same effect as flush. It also clears data registers to 0.
- out_ctrl is the register content when valid, and 0 when EMPTY.
- Data registers are not cleared on flush.
- Order is preserved: main always holds the older entry.

## Timing
- Latency in -> out: 1 cycle (input accepted at edge N is presented after edge N).
- Throughput: 1 transfer per cycle in both modes while out_ready=1.
- SKID=1: one cycle of out_ready=0 is absorbed without dropping in_ready. in_ready falls in the cycle after the second entry is captured.
- Reset values: out_valid=0, out_data=0, out_ctrl=0, occupancy=0. in_ready is 1 (SKID=1), or 1 when out_valid=0 (SKID=0).
- Flush asserted mid-FULL: out_valid=0 and occupancy=0 on the next cycle, and both entries are lost.
- Simultaneous in and out transfer in BUSY: occupancy stays 1, with no bubble inserted.

## Structure
- Shared pipeline package holds:
  - The stage-state enum (EMPTY/BUSY/FULL).
  - The CTRL field bit-position constants (ALU_CTRL lsb/msb, ALU_SRC, MEM_WEN, WB_SEL) used to pack in_ctrl in the decode stage.
  - Default DATA_W/CTRL_W per pipeline boundary.
- One natural sub-module, pipe_entry_reg: a valid + data + ctrl register with load/clear, instantiated as the main entry and, under a generate on SKID, as the skid entry.

## Test plan
- Reset, then idle: out_valid=0, out_ctrl=0x00, occupancy=0, in_ready=1.
- Streaming: in_valid=1 for 4 cycles with data 1,2,3,4 and out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, one cycle later, no bubbles.
- Backpressure (SKID=1): send A,B,C with out_ready=0 for 2 cycles -> occupancy goes 1,2; in_ready=0 after B; C is held upstream; on release, the output order is A,B,C.
- Flush while FULL with ctrl=0xFF (MEM_wen set) -> next cycle out_valid=0, out_ctrl=0x00, occupancy=0; the input offered during flush never appears.
- SKID=0 with out_ready toggling 1,0,1 -> in_ready tracks out_ready whenever out_valid=1, with no entry lost or duplicated.
- Reset asserted with in_valid=1 and occupancy=2 -> next cycle all outputs at reset values; the dropped input is not emitted.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: stage-state encoding, control-field layout and
// default payload widths for each inter-stage boundary.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // Control-field bit positions used by decode when packing in_ctrl
  localparam int unsigned CTRL_ALU_CTRL_LSB = 0;
  localparam int unsigned CTRL_ALU_CTRL_MSB = 3;
  localparam int unsigned CTRL_ALU_SRC      = 4;
  localparam int unsigned CTRL_MEM_WEN      = 5;
  localparam int unsigned CTRL_WB_SEL_LSB   = 6;
  localparam int unsigned CTRL_WB_SEL_MSB   = 7;

  localparam int unsigned DEFAULT_DATA_W = 96;
  localparam int unsigned DEFAULT_CTRL_W = 8;

  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned IF_ID_CTRL_W  = 8;
  localparam int unsigned ID_EX_DATA_W  = 96;
  localparam int unsigned ID_EX_CTRL_W  = 8;
  localparam int unsigned EX_MEM_DATA_W = 72;
  localparam int unsigned EX_MEM_CTRL_W = 8;
  localparam int unsigned MEM_WB_DATA_W = 40;
  localparam int unsigned MEM_WB_CTRL_W = 8;

  function automatic logic [7:0] pack_ctrl(input logic [3:0] alu_ctrl,
                                           input logic       alu_src,
                                           input logic       mem_wen,
                                           input logic [1:0] wb_sel);
    logic [7:0] c;
    c = '0;
    c[CTRL_ALU_CTRL_MSB:CTRL_ALU_CTRL_LSB] = alu_ctrl;
    c[CTRL_ALU_SRC]                        = alu_src;
    c[CTRL_MEM_WEN]                        = mem_wen;
    c[CTRL_WB_SEL_MSB:CTRL_WB_SEL_LSB]     = wb_sel;
    return c;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One held pipeline slot: valid flag plus data and control payloads.
// Control reads as zero whenever the slot is invalid.
module pipe_entry_reg
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned CTRL_W = DEFAULT_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // clear only drops the valid flag; payload registers keep stale contents
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d_data;
      ctrl_d  = d_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign q_valid = valid_q;
  assign q_data  = data_q;
  assign q_ctrl  = valid_q ? ctrl_q : '0;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer and synchronous flush; the main entry always holds the older item.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned CTRL_W = DEFAULT_CTRL_W,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  stage_state_e state_q, state_d;

  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  // With the skid buffer, in_ready is a pure decode of the state register
  assign in_ready = SKID ? (state_q != ST_FULL) : (out_ready | ~main_valid);

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            state_d   = ST_BUSY;
            main_load = 1'b1;
          end
        end
        ST_BUSY: begin
          if (out_ready) begin
            if (in_valid) begin
              main_load = 1'b1;
            end else begin
              state_d    = ST_EMPTY;
              main_clear = 1'b1;
            end
          end else if (in_valid && SKID) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_d        = ST_BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .clear   (main_clear),
    .load    (main_load),
    .d_data  (main_from_skid ? skid_data : in_data),
    .d_ctrl  (main_from_skid ? skid_ctrl : in_ctrl),
    .q_valid (main_valid),
    .q_data  (main_data),
    .q_ctrl  (main_ctrl)
  );

  generate
    if (SKID) begin : g_skid
      pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear   (skid_clear),
        .load    (skid_load),
        .d_data  (in_data),
        .d_ctrl  (in_ctrl),
        .q_valid (skid_valid),
        .q_data  (skid_data),
        .q_ctrl  (skid_ctrl)
      );
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: both SKID variants driven with the same stimulus,
// each checked against a queue-based model, plus directed vector tables.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 96;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  typedef struct {
    bit            iv;
    bit            ordy;
    bit            fl;
    bit            rst;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    bit            ev;
    logic [1:0]    eocc;
    bit            eir;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
  } vec_t;

  logic          clk;
  logic          reset, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DW-1:0] out_data1, out_data0;
  logic [CW-1:0] out_ctrl1, out_ctrl0;
  logic [1:0]    occ1, occ0;

  int n_chk;
  int n_fail;

  ent_t q1[$];
  ent_t q0[$];

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_ctrl(out_ctrl1), .occupancy(occ1)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_ctrl(out_ctrl0), .occupancy(occ0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check pre-edge outputs against the
  // models, then advance the models across the rising edge.
  task automatic step(input bit iv, input bit ordy, input bit fl, input bit rst,
                      input logic [DW-1:0] d, input logic [CW-1:0] c);
    bit   ir1, ir0, ov1, ov0;
    ent_t e;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    in_data   = d;
    in_ctrl   = c;
    e.d = d;
    e.c = c;
    #1;
    ir1 = (q1.size() < 2);
    ov1 = (q1.size() != 0);
    ir0 = ordy || (q0.size() == 0);
    ov0 = (q0.size() != 0);
    chk("s1_in_ready", in_ready1, ir1);
    chk("s1_out_valid", out_valid1, ov1);
    chk("s1_occupancy", occ1, q1.size());
    if (ov1) begin
      chk("s1_out_data", out_data1, q1[0].d);
      chk("s1_out_ctrl", out_ctrl1, q1[0].c);
    end else begin
      chk("s1_out_ctrl_bubble", out_ctrl1, 0);
    end
    chk("s0_in_ready", in_ready0, ir0);
    chk("s0_out_valid", out_valid0, ov0);
    chk("s0_occupancy", occ0, q0.size());
    if (ov0) begin
      chk("s0_out_data", out_data0, q0[0].d);
      chk("s0_out_ctrl", out_ctrl0, q0[0].c);
    end else begin
      chk("s0_out_ctrl_bubble", out_ctrl0, 0);
    end
    @(posedge clk);
    if (rst || fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (ov1 && ordy) void'(q1.pop_front());
      if (iv && ir1) q1.push_back(e);
      if (ov0 && ordy) void'(q0.pop_front());
      if (iv && ir0) q0.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s1_out_valid"}, out_valid1, 0);
    chk({tag, "_s1_out_data"}, out_data1, 0);
    chk({tag, "_s1_out_ctrl"}, out_ctrl1, 0);
    chk({tag, "_s1_occupancy"}, occ1, 0);
    chk({tag, "_s1_in_ready"}, in_ready1, 1);
    chk({tag, "_s0_out_valid"}, out_valid0, 0);
    chk({tag, "_s0_out_data"}, out_data0, 0);
    chk({tag, "_s0_out_ctrl"}, out_ctrl0, 0);
    chk({tag, "_s0_occupancy"}, occ0, 0);
    chk({tag, "_s0_in_ready"}, in_ready0, 1);
  endtask

  vec_t tbl[0:13];

  initial begin
    n_chk  = 0;
    n_fail = 0;

    tbl[0]  = '{1, 1, 0, 0, 96'h1,   8'h11, 1, 2'd1, 1, 96'h1,   8'h11};
    tbl[1]  = '{1, 1, 0, 0, 96'h2,   8'h12, 1, 2'd1, 1, 96'h2,   8'h12};
    tbl[2]  = '{1, 1, 0, 0, 96'h3,   8'h13, 1, 2'd1, 1, 96'h3,   8'h13};
    tbl[3]  = '{1, 1, 0, 0, 96'h4,   8'h14, 1, 2'd1, 1, 96'h4,   8'h14};
    tbl[4]  = '{0, 1, 0, 0, 96'h0,   8'h00, 0, 2'd0, 1, 96'h0,   8'h00};
    tbl[5]  = '{1, 0, 0, 0, 96'hA,   8'h21, 1, 2'd1, 1, 96'hA,   8'h21};
    tbl[6]  = '{1, 0, 0, 0, 96'hB,   8'h22, 1, 2'd2, 0, 96'hA,   8'h21};
    tbl[7]  = '{1, 1, 0, 0, 96'hC,   8'h23, 1, 2'd1, 1, 96'hB,   8'h22};
    tbl[8]  = '{1, 1, 0, 0, 96'hC,   8'h23, 1, 2'd1, 1, 96'hC,   8'h23};
    tbl[9]  = '{0, 1, 0, 0, 96'h0,   8'h00, 0, 2'd0, 1, 96'h0,   8'h00};
    tbl[10] = '{1, 0, 0, 0, 96'hE1,  8'hFF, 1, 2'd1, 1, 96'hE1,  8'hFF};
    tbl[11] = '{1, 0, 0, 0, 96'hE2,  8'hFF, 1, 2'd2, 0, 96'hE1,  8'hFF};
    tbl[12] = '{1, 0, 1, 0, 96'hDD,  8'hFF, 0, 2'd0, 1, 96'h0,   8'h00};
    tbl[13] = '{0, 1, 0, 0, 96'h0,   8'h00, 0, 2'd0, 1, 96'h0,   8'h00};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("reset");
    step(0, 0, 0, 0, '0, '0);
    chk_reset_vals("idle");

    // Streaming, backpressure and flush-while-full on the skid variant
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].rst, tbl[i].d, tbl[i].c);
      chk($sformatf("vec%0d_out_valid", i), out_valid1, tbl[i].ev);
      chk($sformatf("vec%0d_occupancy", i), occ1, tbl[i].eocc);
      chk($sformatf("vec%0d_in_ready", i), in_ready1, tbl[i].eir);
      chk($sformatf("vec%0d_out_ctrl", i), out_ctrl1, tbl[i].ec);
      if (tbl[i].ev) chk($sformatf("vec%0d_out_data", i), out_data1, tbl[i].ed);
    end

    // Single-entry variant with out_ready toggling while holding data
    step(1, 1, 0, 0, 96'h51, 8'h31);
    step(1, 0, 0, 0, 96'h52, 8'h32);
    chk("s0_toggle_hold_ready", in_ready0, 0);
    step(1, 1, 0, 0, 96'h52, 8'h32);
    step(1, 0, 0, 0, 96'h53, 8'h33);
    step(1, 1, 0, 0, 96'h53, 8'h33);
    step(0, 1, 0, 0, '0, '0);
    step(0, 1, 0, 0, '0, '0);

    // Reset with the skid variant full and an input offered
    step(1, 0, 0, 0, 96'h61, 8'h41);
    step(1, 0, 0, 0, 96'h62, 8'h42);
    chk("pre_reset_occupancy", occ1, 2);
    step(1, 0, 0, 1, 96'h63, 8'hFF);
    chk_reset_vals("mid_reset");
    step(0, 1, 0, 0, '0, '0);
    chk("post_reset_no_emit", out_valid1, 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 32) == 0,
           ($urandom % 64) == 0, {$urandom, $urandom, $urandom}, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
